// File: rtl/cpu_param_pkg.sv
// Shared definitions for the parametrised multi-cycle CPU.
// Contents: opcode encoding, controller state encoding and the bit
// positions of the condition flags inside the 3-bit flags word
// {NF, CF, ZF}.
package cpu_param_pkg;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_ADD  = 4'h1,
    OP_SUB  = 4'h2,
    OP_AND  = 4'h3,
    OP_OR   = 4'h4,
    OP_ADDI = 4'h5,
    OP_SUBI = 4'h6,
    OP_LD   = 4'h7,
    OP_ST   = 4'h8,
    OP_JMP  = 4'h9,
    OP_JZ   = 4'hA,
    OP_JC   = 4'hB,
    OP_JN   = 4'hC,
    OP_IN   = 4'hD,
    OP_OUT  = 4'hE,
    OP_HALT = 4'hF
  } opcode_e;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_MEM   = 2'd2,
    ST_HALT  = 2'd3
  } state_e;

  localparam int FLAG_ZF = 0;
  localparam int FLAG_CF = 1;
  localparam int FLAG_NF = 2;

endpackage

// File: rtl/alu_param.sv
// Combinational ALU for the multi-cycle CPU.
// Ports:
//   op_i  : opcode (ADD/ADDI add, SUB/SUBI subtract, AND, OR; others give 0)
//   a_i   : left operand (destination register value)
//   b_i   : right operand (register or immediate)
//   res_o : result, modulo 2^DATA_W
//   cf_o  : carry-out for add, borrow for subtract, 0 for logic ops
//   zf_o  : result is zero
//   nf_o  : result MSB
module alu_param
  import cpu_param_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [3:0]        op_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [DATA_W-1:0] res_o,
  output logic              cf_o,
  output logic              zf_o,
  output logic              nf_o
);

  // One extra bit catches the carry-out, or the borrow on subtraction
  // (the extended difference goes negative exactly when a < b unsigned).
  logic [DATA_W:0] ext;

  always_comb begin
    ext   = '0;
    res_o = '0;
    cf_o  = 1'b0;
    case (opcode_e'(op_i))
      OP_ADD, OP_ADDI: begin
        ext   = {1'b0, a_i} + {1'b0, b_i};
        res_o = ext[DATA_W-1:0];
        cf_o  = ext[DATA_W];
      end
      OP_SUB, OP_SUBI: begin
        ext   = {1'b0, a_i} - {1'b0, b_i};
        res_o = ext[DATA_W-1:0];
        cf_o  = ext[DATA_W];
      end
      OP_AND:  res_o = a_i & b_i;
      OP_OR:   res_o = a_i | b_i;
      default: res_o = '0;
    endcase
    zf_o = (res_o == '0);
    nf_o = res_o[DATA_W-1];
  end

endmodule

// File: rtl/cpu_multicycle_param.sv
// Parametrised multi-cycle CPU with unified program/data memory.
// Ports:
//   clk, reset        : clock, asynchronous active-high reset
//   run               : core advances out of FETCH only while high
//   prog_we/addr/wdata: host memory write port, honoured only when run=0
//   in_data/in_valid  : input operand for IN; in_ready pulses on consume
//   out_data/out_valid: last OUT value (held); out_valid pulses per OUT
//   pc, ir, flags     : program counter, instruction register, {NF,CF,ZF}
//   halted            : core has executed HALT
module cpu_multicycle_param
  import cpu_param_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 4,
  parameter int RSEL_W  = 2,
  parameter int INSTR_W = 4 + RSEL_W + DATA_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               run,
  input  logic               prog_we,
  input  logic [ADDR_W-1:0]  prog_addr,
  input  logic [INSTR_W-1:0] prog_wdata,
  input  logic [DATA_W-1:0]  in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [DATA_W-1:0]  out_data,
  output logic               out_valid,
  output logic [ADDR_W-1:0]  pc,
  output logic [INSTR_W-1:0] ir,
  output logic [2:0]         flags,
  output logic               halted
);

  localparam int NREG  = 1 << RSEL_W;
  localparam int DEPTH = 1 << ADDR_W;

  state_e             state_q;
  logic [ADDR_W-1:0]  pc_q;
  logic [INSTR_W-1:0] ir_q;
  logic [2:0]         flags_q;
  logic [DATA_W-1:0]  out_data_q;
  logic               out_valid_q;
  logic               in_ready_q;
  logic               halted_q;
  logic [DATA_W-1:0]  regs_q [NREG];
  logic [INSTR_W-1:0] mem_q  [DEPTH];

  // Instruction decode
  opcode_e            op;
  logic [RSEL_W-1:0]  rd;
  logic [DATA_W-1:0]  f;
  logic [RSEL_W-1:0]  rb;
  logic [ADDR_W-1:0]  addr;
  logic [DATA_W-1:0]  rd_val;
  logic [DATA_W-1:0]  alu_b;
  logic [DATA_W-1:0]  alu_res;
  logic               alu_cf, alu_zf, alu_nf;
  logic [ADDR_W-1:0]  pc_inc;
  logic               jmp_take;
  logic               host_we;
  logic               st_we;

  assign op      = opcode_e'(ir_q[INSTR_W-1 -: 4]);
  assign rd      = ir_q[INSTR_W-5 -: RSEL_W];
  assign f       = ir_q[DATA_W-1:0];
  assign rb      = f[DATA_W-1 -: RSEL_W];
  assign addr    = f[ADDR_W-1:0];
  assign rd_val  = regs_q[rd];
  assign alu_b   = (op == OP_ADDI || op == OP_SUBI) ? f : regs_q[rb];
  assign pc_inc  = pc_q + ADDR_W'(1);

  always_comb begin
    jmp_take = 1'b0;
    case (op)
      OP_JMP:  jmp_take = 1'b1;
      OP_JZ:   jmp_take = flags_q[FLAG_ZF];
      OP_JC:   jmp_take = flags_q[FLAG_CF];
      OP_JN:   jmp_take = flags_q[FLAG_NF];
      default: jmp_take = 1'b0;
    endcase
  end

  alu_param #(.DATA_W(DATA_W)) u_alu (
    .op_i  (ir_q[INSTR_W-1 -: 4]),
    .a_i   (rd_val),
    .b_i   (alu_b),
    .res_o (alu_res),
    .cf_o  (alu_cf),
    .zf_o  (alu_zf),
    .nf_o  (alu_nf)
  );

  // Memory is not reset. The ST write is qualified with reset so that an
  // aborted MEM cycle never commits; the host port only works while stopped.
  assign host_we = prog_we && !run;
  assign st_we   = (state_q == ST_MEM) && (op == OP_ST) && !reset;

  always_ff @(posedge clk) begin
    if (st_we) begin
      mem_q[addr] <= {{(INSTR_W-DATA_W){1'b0}}, rd_val};
    end else if (host_we) begin
      mem_q[prog_addr] <= prog_wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_FETCH;
      pc_q        <= '0;
      ir_q        <= '0;
      flags_q     <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
      halted_q    <= 1'b0;
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else begin
      // Handshake outputs are single-cycle pulses.
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
      case (state_q)
        ST_FETCH: begin
          if (run) begin
            ir_q    <= mem_q[pc_q];
            state_q <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          state_q <= ST_FETCH;
          pc_q    <= pc_inc;
          case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI, OP_SUBI: begin
              regs_q[rd]       <= alu_res;
              flags_q[FLAG_ZF] <= alu_zf;
              flags_q[FLAG_CF] <= alu_cf;
              flags_q[FLAG_NF] <= alu_nf;
            end
            OP_LD, OP_ST: begin
              state_q <= ST_MEM;
              pc_q    <= pc_q;
            end
            OP_JMP, OP_JZ, OP_JC, OP_JN: begin
              if (jmp_take) pc_q <= addr;
            end
            OP_IN: begin
              // Stay in EXEC with pc held until the operand arrives.
              if (in_valid) begin
                regs_q[rd] <= in_data;
                in_ready_q <= 1'b1;
              end else begin
                state_q <= ST_EXEC;
                pc_q    <= pc_q;
              end
            end
            OP_OUT: begin
              out_data_q  <= rd_val;
              out_valid_q <= 1'b1;
            end
            OP_HALT: begin
              state_q  <= ST_HALT;
              pc_q     <= pc_q;
              halted_q <= 1'b1;
            end
            default: ;
          endcase
        end
        ST_MEM: begin
          if (op == OP_LD) regs_q[rd] <= mem_q[addr][DATA_W-1:0];
          pc_q    <= pc_inc;
          state_q <= ST_FETCH;
        end
        ST_HALT: begin
          halted_q <= 1'b1;
        end
        default: state_q <= ST_FETCH;
      endcase
    end
  end

  assign pc        = pc_q;
  assign ir        = ir_q;
  assign flags     = flags_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign in_ready  = in_ready_q;
  assign halted    = halted_q;

endmodule

// File: tb/tb_cpu_multicycle_param.sv
// Scoreboard bench for cpu_multicycle_param with default parameters
// (DATA_W=8, ADDR_W=4, RSEL_W=2, 14-bit instructions). Directed programs
// push the OUT values they should produce; a monitor pops and compares on
// every out_valid pulse.
module tb_cpu_multicycle_param;

  localparam int DATA_W  = 8;
  localparam int ADDR_W  = 4;
  localparam int RSEL_W  = 2;
  localparam int INSTR_W = 14;

  localparam logic [3:0] O_NOP = 4'h0, O_ADDI = 4'h5, O_SUBI = 4'h6,
                         O_LD = 4'h7, O_ST = 4'h8, O_JMP = 4'h9, O_JZ = 4'hA,
                         O_JN = 4'hC, O_IN = 4'hD, O_OUT = 4'hE, O_HALT = 4'hF;

  logic               clk;
  logic               reset;
  logic               run;
  logic               prog_we;
  logic [ADDR_W-1:0]  prog_addr;
  logic [INSTR_W-1:0] prog_wdata;
  logic [DATA_W-1:0]  in_data;
  logic               in_valid;
  logic               in_ready;
  logic [DATA_W-1:0]  out_data;
  logic               out_valid;
  logic [ADDR_W-1:0]  pc;
  logic [INSTR_W-1:0] ir;
  logic [2:0]         flags;
  logic               halted;

  cpu_multicycle_param #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RSEL_W(RSEL_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .run        (run),
    .prog_we    (prog_we),
    .prog_addr  (prog_addr),
    .prog_wdata (prog_wdata),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .pc         (pc),
    .ir         (ir),
    .flags      (flags),
    .halted     (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int in_ready_cnt = 0;
  logic [DATA_W-1:0]  exp_q [$];
  logic [INSTR_W-1:0] img [16];

  function automatic logic [INSTR_W-1:0] enc(input logic [3:0] op,
                                             input logic [1:0] r,
                                             input logic [7:0] fld);
    return {op, r, fld};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every OUT pulse is matched against the oldest expected value.
  always @(negedge clk) begin
    if (!reset && out_valid) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL out_unexpected: got 0x%0h expected no output", out_data);
      end else begin
        chk("out_data", {24'b0, out_data}, {24'b0, exp_q.pop_front()});
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && in_ready) in_ready_cnt++;
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    run   = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic write_word(input logic [ADDR_W-1:0] a, input logic [INSTR_W-1:0] d);
    prog_we    = 1'b1;
    prog_addr  = a;
    prog_wdata = d;
    @(negedge clk);
    prog_we    = 1'b0;
  endtask

  task automatic fill_halt();
    for (int i = 0; i < 16; i++) img[i] = enc(O_HALT, 2'd0, 8'h00);
  endtask

  task automatic load_img();
    for (int i = 0; i < 16; i++) write_word(ADDR_W'(i), img[i]);
  endtask

  task automatic run_until_halt(input string name, input int exp_cycles);
    int cycles;
    cycles = 0;
    run = 1'b1;
    do begin
      @(negedge clk);
      cycles++;
    end while (!halted && cycles < 300);
    run = 1'b0;
    chk(name, cycles, exp_cycles);
  endtask

  task automatic drained(input string name);
    chk(name, exp_q.size(), 0);
  endtask

  initial begin
    int base;
    int waited;
    reset = 1'b1; run = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_wdata = '0;
    in_data = '0; in_valid = 1'b0;

    // Reset state
    do_reset();
    #1;
    chk("rst_pc", pc, 0);
    chk("rst_ir", ir, 0);
    chk("rst_flags", flags, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_halted", halted, 0);

    // ADDI/ADDI/OUT/HALT
    fill_halt();
    img[0] = enc(O_ADDI, 2'd0, 8'd5);
    img[1] = enc(O_ADDI, 2'd0, 8'd3);
    img[2] = enc(O_OUT,  2'd0, 8'd0);
    load_img();
    exp_q.push_back(8'd8);
    run_until_halt("t1_cycles", 8);
    chk("t1_pc", pc, 3);
    chk("t1_halted", halted, 1);
    chk("t1_flags", flags, 3'b000);
    drained("t1_drained");

    // Carry-out to zero
    do_reset();
    fill_halt();
    img[0] = enc(O_ADDI, 2'd1, 8'hFF);
    img[1] = enc(O_ADDI, 2'd1, 8'h01);
    img[2] = enc(O_OUT,  2'd1, 8'h00);
    load_img();
    exp_q.push_back(8'h00);
    run_until_halt("t2a_cycles", 8);
    chk("t2a_flags", flags, 3'b011);
    drained("t2a_drained");

    // Borrow to 0xFF
    do_reset();
    fill_halt();
    img[0] = enc(O_ADDI, 2'd1, 8'hFF);
    img[1] = enc(O_ADDI, 2'd1, 8'h01);
    img[2] = enc(O_SUBI, 2'd1, 8'h01);
    img[3] = enc(O_OUT,  2'd1, 8'h00);
    load_img();
    exp_q.push_back(8'hFF);
    run_until_halt("t2b_cycles", 10);
    chk("t2b_flags", flags, 3'b110);
    drained("t2b_drained");

    // ST/LD plus self-modification: word 14 starts as HALT, the ST turns it
    // into 0x005A (a NOP) so the core runs on to the HALT at 15.
    do_reset();
    fill_halt();
    img[0] = enc(O_ADDI, 2'd0, 8'h5A);
    img[1] = enc(O_ST,   2'd0, 8'h0E);
    img[2] = enc(O_LD,   2'd2, 8'h0E);
    img[3] = enc(O_OUT,  2'd2, 8'h00);
    img[4] = enc(O_JMP,  2'd0, 8'h0E);
    load_img();
    exp_q.push_back(8'h5A);
    run_until_halt("t3_cycles", 16);
    chk("t3_pc", pc, 15);
    drained("t3_drained");

    // IN waits for in_valid
    do_reset();
    fill_halt();
    img[0] = enc(O_IN,  2'd3, 8'h00);
    img[1] = enc(O_OUT, 2'd3, 8'h00);
    load_img();
    base = in_ready_cnt;
    run = 1'b1;
    repeat (6) @(negedge clk);
    chk("t4_wait_pc", pc, 0);
    chk("t4_wait_ir", ir, enc(O_IN, 2'd3, 8'h00));
    chk("t4_wait_ready", in_ready_cnt - base, 0);
    in_data  = 8'h21;
    in_valid = 1'b1;
    exp_q.push_back(8'h21);
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!in_ready && waited < 10);
    in_valid = 1'b0;
    chk("t4_ready_latency", waited, 1);
    run_until_halt("t4_cycles", 4);
    chk("t4_pc", pc, 2);
    chk("t4_ready_pulses", in_ready_cnt - base, 1);
    drained("t4_drained");

    // JZ taken
    do_reset();
    fill_halt();
    img[0] = enc(O_ADDI, 2'd0, 8'h01);
    img[1] = enc(O_SUBI, 2'd0, 8'h01);
    img[2] = enc(O_JZ,   2'd0, 8'h07);
    img[7] = enc(O_OUT,  2'd0, 8'h00);
    load_img();
    exp_q.push_back(8'h00);
    run_until_halt("t5a_cycles", 10);
    chk("t5a_pc", pc, 8);
    chk("t5a_flags", flags, 3'b001);
    drained("t5a_drained");

    // JZ not taken
    do_reset();
    fill_halt();
    img[0] = enc(O_ADDI, 2'd0, 8'h01);
    img[1] = enc(O_JZ,   2'd0, 8'h07);
    img[2] = enc(O_OUT,  2'd0, 8'h00);
    img[7] = enc(O_OUT,  2'd0, 8'h00);
    load_img();
    exp_q.push_back(8'h01);
    run_until_halt("t5b_cycles", 8);
    chk("t5b_pc", pc, 3);
    drained("t5b_drained");

    // NOP at 15 wraps pc to 0; JN first not taken, then taken
    do_reset();
    fill_halt();
    img[0]  = enc(O_JN,   2'd0, 8'h04);
    img[1]  = enc(O_ADDI, 2'd0, 8'h80);
    img[2]  = enc(O_JMP,  2'd0, 8'h0F);
    img[4]  = enc(O_OUT,  2'd0, 8'h00);
    img[15] = enc(O_NOP,  2'd0, 8'h00);
    load_img();
    exp_q.push_back(8'h80);
    run_until_halt("t5c_cycles", 14);
    chk("t5c_pc", pc, 5);
    chk("t5c_flags", flags, 3'b100);
    drained("t5c_drained");

    // Reset during MEM of an ST aborts it
    do_reset();
    fill_halt();
    img[0]  = enc(O_ADDI, 2'd0, 8'h33);
    img[1]  = enc(O_ST,   2'd0, 8'h0E);
    img[14] = enc(O_HALT, 2'd0, 8'h77);
    load_img();
    run = 1'b1;
    repeat (4) @(negedge clk);
    chk("t6_pre_pc", pc, 1);
    reset = 1'b1;
    run   = 1'b0;
    #1;
    chk("t6_async_pc", pc, 0);
    chk("t6_async_ir", ir, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    write_word(4'd0, enc(O_LD,   2'd1, 8'h0E));
    write_word(4'd1, enc(O_OUT,  2'd1, 8'h00));
    write_word(4'd2, enc(O_OUT,  2'd0, 8'h00));
    write_word(4'd3, enc(O_HALT, 2'd0, 8'h00));
    exp_q.push_back(8'h77);
    exp_q.push_back(8'h00);
    run_until_halt("t6_cycles", 9);
    chk("t6_pc", pc, 3);
    drained("t6_drained");

    // Drop run mid-program; host write while running is ignored
    do_reset();
    fill_halt();
    img[0] = enc(O_ADDI, 2'd0, 8'h01);
    img[1] = enc(O_ADDI, 2'd0, 8'h01);
    img[2] = enc(O_ADDI, 2'd0, 8'h01);
    img[3] = enc(O_OUT,  2'd0, 8'h00);
    load_img();
    run        = 1'b1;
    prog_we    = 1'b1;
    prog_addr  = 4'd4;
    prog_wdata = enc(O_NOP, 2'd0, 8'h00);
    @(negedge clk);
    prog_we = 1'b0;
    repeat (2) @(negedge clk);
    run = 1'b0;
    repeat (5) @(negedge clk);
    chk("t7_stall_pc", pc, 2);
    chk("t7_stall_ir", ir, enc(O_ADDI, 2'd0, 8'h01));
    chk("t7_stall_halted", halted, 0);
    exp_q.push_back(8'h03);
    run_until_halt("t7_cycles", 6);
    chk("t7_pc", pc, 4);
    drained("t7_drained");

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
